read_burst_issuer: RTL and testbench

Upstream companion of the read burst aligner in the vector load path. Accepts byte-granular load requests (address, length), splits each into beat-aligned memory read bursts, and tags returning read beats with start/end markers and the byte shift amount. The aligner then consumes them. Up to DEPTH requests may be in flight. Returning data is passed on with one cycle of latency.

---
 rtl/read_burst_issuer.sv | 167 ++++++++++++++++
 tb/tb_read_burst_issuer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/read_burst_issuer.sv
// read_burst_issuer: splits byte-granular load requests into beat-aligned
// read bursts and tags the returning beats with start/end markers and the
// byte shift the downstream aligner needs.
module read_burst_issuer #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_BURST  = 16,
    parameter int DEPTH      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [ADDR_WIDTH-1:0]                req_addr,
    input  logic [LEN_WIDTH-1:0]                 req_len,
    output logic                                 ar_valid,
    input  logic                                 ar_ready,
    output logic [ADDR_WIDTH-1:0]                ar_addr,
    output logic [7:0]                           ar_len,
    input  logic                                 r_valid,
    output logic                                 r_ready,
    input  logic [DATA_WIDTH-1:0]                r_data,
    output logic                                 o_valid,
    output logic                                 o_start,
    output logic                                 o_end,
    output logic [DATA_WIDTH-1:0]                o_data,
    output logic [$clog2(DATA_WIDTH/8)-1:0]      o_shamt
);
    localparam int B   = DATA_WIDTH / 8;
    localparam int SHW = $clog2(B);
    localparam int NW  = LEN_WIDTH + 1;
    localparam int PW  = $clog2(DEPTH);
    localparam int EW  = SHW + NW;

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_ISSUE = 1'b1;

    logic                  state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [NW-1:0]         beats_left_q, beats_left_d;
    logic [NW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [EW-1:0]         fifo_mem_q [DEPTH];
    logic [EW-1:0]         fifo_mem_d [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;
    logic                  o_valid_q, o_valid_d, o_start_q, o_start_d, o_end_q, o_end_d;
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
    logic [SHW-1:0]        o_shamt_q, o_shamt_d;

    logic [SHW-1:0] req_offset;
    logic [NW-1:0]  len_beats, n_req, chunk, head_n;
    logic [SHW-1:0] head_shamt;
    logic           fifo_full, fifo_empty, req_fire, push, r_fire, last_beat, pop;

    // Request sizing: the extra beat for a misaligned start is always added.
    always_comb begin
        req_offset = req_addr[SHW-1:0];
        len_beats  = ({1'b0, req_len} + NW'(B - 1)) >> SHW;
        n_req      = len_beats + NW'(req_offset != '0);
        chunk      = (beats_left_q > NW'(MAX_BURST)) ? NW'(MAX_BURST) : beats_left_q;
    end

    assign fifo_full  = (count_q == (PW+1)'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head_n     = fifo_mem_q[rd_ptr_q][NW-1:0];
    assign head_shamt = fifo_mem_q[rd_ptr_q][EW-1:NW];

    assign req_ready = (state_q == S_IDLE) && !fifo_full && !rst;
    assign req_fire  = req_valid && req_ready;
    assign push      = req_fire && (req_len != '0);
    assign r_ready   = !fifo_empty && !rst;
    assign r_fire    = r_valid && r_ready;
    assign last_beat = (beat_cnt_q == head_n - NW'(1));
    assign pop       = r_fire && last_beat;

    assign ar_valid = (state_q == S_ISSUE);
    assign ar_addr  = cur_addr_q;
    assign ar_len   = ar_valid ? 8'(chunk - NW'(1)) : 8'd0;

    assign o_valid = o_valid_q;
    assign o_start = o_start_q;
    assign o_end   = o_end_q;
    assign o_data  = o_data_q;
    assign o_shamt = o_shamt_q;

    // Issue FSM: accept a request, then walk it out in MAX_BURST-sized chunks.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        if (state_q == S_IDLE) begin
            if (push) begin
                cur_addr_d   = {req_addr[ADDR_WIDTH-1:SHW], {SHW{1'b0}}};
                beats_left_d = n_req;
                state_d      = S_ISSUE;
            end
        end else if (ar_ready) begin
            cur_addr_d   = cur_addr_q + (ADDR_WIDTH'(chunk) << SHW);
            beats_left_d = beats_left_q - chunk;
            if (beats_left_q == chunk) begin
                state_d = S_IDLE;
            end
        end
    end

    // Metadata FIFO: {shamt, N} per request; push and pop may coincide.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);
        if (push) begin
            fifo_mem_d[wr_ptr_q] = {req_offset, n_req};
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Return side: frame beats purely by count against the FIFO head.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (r_fire) begin
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + NW'(1);
        end
        o_valid_d = r_fire;
        o_start_d = r_fire && (beat_cnt_q == '0);
        o_end_d   = r_fire && last_beat;
        o_data_d  = r_fire ? r_data : o_data_q;
        o_shamt_d = r_fire ? head_shamt : o_shamt_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            beat_cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            o_valid_q    <= 1'b0;
            o_start_q    <= 1'b0;
            o_end_q      <= 1'b0;
            o_data_q     <= '0;
            o_shamt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            beat_cnt_q   <= beat_cnt_d;
            fifo_mem_q   <= fifo_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            o_valid_q    <= o_valid_d;
            o_start_q    <= o_start_d;
            o_end_q      <= o_end_d;
            o_data_q     <= o_data_d;
            o_shamt_q    <= o_shamt_d;
        end
    end
endmodule

// File: tb/tb_read_burst_issuer.sv
// Directed bench for read_burst_issuer (B=8, MAX_BURST=16, DEPTH=4).
module tb_read_burst_issuer;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic [15:0] req_len;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic        r_valid, r_ready;
    logic [63:0] r_data;
    logic        o_valid, o_start, o_end;
    logic [63:0] o_data;
    logic [2:0]  o_shamt;

    int total = 0;
    int bad   = 0;

    read_burst_issuer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .o_valid(o_valid), .o_start(o_start), .o_end(o_end), .o_data(o_data), .o_shamt(o_shamt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input int tag, input int i);
        return 64'hBEEF_0000_0000_0000 | (64'(tag) << 16) | 64'(i);
    endfunction

    // Single-burst request: wait for ready, hand over, check and retire the burst.
    task automatic do_req(input logic [31:0] addr, input logic [15:0] len,
                          input logic [31:0] exp_addr, input logic [7:0] exp_len);
        int w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_wait", req_ready, 1'b1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len;
        @(negedge clk);
        req_valid = 1'b0;
        chk("ar_valid", ar_valid, 1'b1);
        chk("ar_addr", ar_addr, exp_addr);
        chk("ar_len", ar_len, exp_len);
        @(negedge clk);
        chk("ar_done", ar_valid, 1'b0);
    endtask

    // Feed n_send beats of an n_total-beat request and check the tagged output.
    task automatic run_beats(input int n_total, input int n_send, input int tag, input logic [2:0] shamt);
        chk("r_ready", r_ready, 1'b1);
        for (int i = 0; i < n_send; i++) begin
            r_valid = 1'b1;
            r_data  = beat_data(tag, i);
            @(negedge clk);
            chk("o_valid", o_valid, 1'b1);
            chk("o_start", o_start, i == 0);
            chk("o_end", o_end, i == n_total - 1);
            chk("o_data", o_data, beat_data(tag, i));
            chk("o_shamt", o_shamt, shamt);
        end
        r_valid = 1'b0;
        @(negedge clk);
        chk("o_idle", o_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
        ar_ready = 1'b1; r_valid = 1'b0; r_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_ar_valid", ar_valid, 1'b0);
        chk("rst_ar_addr", ar_addr, 32'h0);
        chk("rst_ar_len", ar_len, 8'h0);
        chk("rst_r_ready", r_ready, 1'b0);
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o_data", o_data, 64'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", req_ready, 1'b1);
        @(negedge clk);

        // aligned 32 bytes -> 4 beats, one burst
        do_req(32'h100, 16'd32, 32'h100, 8'd3);
        run_beats(4, 4, 1, 3'd0);

        // 4 bytes at offset 3 -> 2 beats
        do_req(32'h103, 16'd4, 32'h100, 8'd1);
        run_beats(2, 2, 2, 3'd3);

        // 160 bytes at offset 5 -> 21 beats, bursts 16 + 5, with a 5-cycle ar stall
        ar_ready  = 1'b0;
        req_valid = 1'b1; req_addr = 32'h205; req_len = 16'd160;
        @(negedge clk);
        req_addr = 32'h900; req_len = 16'd8;
        for (int k = 0; k < 5; k++) begin
            chk("stall_ar_valid", ar_valid, 1'b1);
            chk("stall_ar_addr", ar_addr, 32'h200);
            chk("stall_ar_len", ar_len, 8'd15);
            chk("stall_req_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        ar_ready  = 1'b1;
        @(negedge clk);
        chk("b2_ar_valid", ar_valid, 1'b1);
        chk("b2_ar_addr", ar_addr, 32'h280);
        chk("b2_ar_len", ar_len, 8'd4);
        @(negedge clk);
        chk("b2_done", ar_valid, 1'b0);
        chk("b2_req_ready", req_ready, 1'b1);
        run_beats(21, 21, 3, 3'd5);

        // fill the metadata FIFO with r_valid low
        do_req(32'h1000, 16'd8, 32'h1000, 8'd0);
        do_req(32'h2000, 16'd16, 32'h2000, 8'd1);
        do_req(32'h3001, 16'd8, 32'h3000, 8'd1);
        do_req(32'h4000, 16'd8, 32'h4000, 8'd0);
        chk("full_req_ready", req_ready, 1'b0);
        chk("full_r_ready", r_ready, 1'b1);
        // single-beat request pops, ready returns next cycle
        r_valid = 1'b1; r_data = beat_data(4, 0);
        @(negedge clk);
        r_valid = 1'b0;
        chk("pop_req_ready", req_ready, 1'b1);
        chk("pop_o_start", o_start, 1'b1);
        chk("pop_o_end", o_end, 1'b1);
        chk("pop_o_data", o_data, beat_data(4, 0));
        // second request: beat 0, then beat 1 (pop) together with a new push
        r_valid = 1'b1; r_data = beat_data(5, 0);
        @(negedge clk);
        chk("pp_b0_start", o_start, 1'b1);
        chk("pp_b0_end", o_end, 1'b0);
        r_data = beat_data(5, 1);
        req_valid = 1'b1; req_addr = 32'h5000; req_len = 16'd8;
        @(negedge clk);
        r_valid = 1'b0; req_valid = 1'b0;
        chk("pp_b1_end", o_end, 1'b1);
        chk("pp_b1_data", o_data, beat_data(5, 1));
        chk("pp_ar_valid", ar_valid, 1'b1);
        chk("pp_ar_addr", ar_addr, 32'h5000);
        @(negedge clk);
        chk("pp_count3_ready", req_ready, 1'b1);
        do_req(32'h6000, 16'd8, 32'h6000, 8'd0);
        chk("refull_req_ready", req_ready, 1'b0);
        run_beats(2, 2, 6, 3'd1);
        run_beats(1, 1, 7, 3'd0);
        run_beats(1, 1, 8, 3'd0);
        run_beats(1, 1, 9, 3'd0);
        chk("drained_r_ready", r_ready, 1'b0);

        // reset after 2 of 4 beats
        do_req(32'h700, 16'd32, 32'h700, 8'd3);
        run_beats(4, 2, 10, 3'd0);
        rst = 1'b1;
        r_valid = 1'b1; r_data = beat_data(11, 0);
        @(negedge clk);
        chk("mid_rst_req_ready", req_ready, 1'b0);
        chk("mid_rst_r_ready", r_ready, 1'b0);
        chk("mid_rst_ar_valid", ar_valid, 1'b0);
        chk("mid_rst_o_valid", o_valid, 1'b0);
        chk("mid_rst_o_data", o_data, 64'h0);
        chk("mid_rst_o_shamt", o_shamt, 3'd0);
        rst = 1'b0;
        #1;
        chk("after_rst_r_ready", r_ready, 1'b0);
        @(negedge clk);
        chk("stale_beat_dropped", o_valid, 1'b0);
        r_valid = 1'b0;

        // zero-length request is consumed silently
        req_valid = 1'b1; req_addr = 32'h800; req_len = 16'd0;
        chk("zero_req_ready", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("zero_ar_valid", ar_valid, 1'b0);
        chk("zero_r_ready", r_ready, 1'b0);
        chk("zero_req_ready_after", req_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
